// File: rtl/mesh_sequencer.sv
// mesh_sequencer: run-level controller for an NxN systolic mesh.
//
// One job per accepted start: hold the mesh in reset, stream skewed queue
// reads with feed valid and a last-element pulse, then wait for the mesh
// done flag plus a drain pulse from every row before reporting completion.
// A job that never completes within TIMEOUT wait cycles reports an error.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           job request (accepted only when idle)
//   k_len_i           operand stream length K, latched with an accepted start
//   acc_sel_i         accumulator bank, latched with an accepted start
//   abort_i           cancel the running job
//   mesh_done_i       sticky mesh done flag
//   drain_i[N]        per-row drain pulses
//   mesh_rstn_o       active-low mesh reset
//   queue_rd_en_o[N]  skewed read enables for row/column queue r
//   inputs_valid_o    feed valid to the top-left PE
//   last_element_o    one-cycle last-element pulse
//   acc_sel_o         latched bank select
//   busy_o            high whenever a job is in progress
//   done_o            one-cycle completion pulse
//   error_o           one-cycle pulse on a rejected start or a timeout
module mesh_sequencer #(
    parameter int N          = 4,
    parameter int KW         = 16,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [KW-1:0] k_len_i,
    input  logic          acc_sel_i,
    input  logic          abort_i,
    input  logic          mesh_done_i,
    input  logic [N-1:0]  drain_i,
    output logic          mesh_rstn_o,
    output logic [N-1:0]  queue_rd_en_o,
    output logic          inputs_valid_o,
    output logic          last_element_o,
    output logic          acc_sel_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o
);

    // Feed counter must reach K+N-2 without wrapping.
    localparam int TW  = KW + $clog2(N) + 1;
    localparam int CW  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
    localparam int TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [KW-1:0]   k_r, k_s;
    logic [TW-1:0]   t_r, t_s;
    logic [CW-1:0]   clr_r, clr_s;
    logic [TOW-1:0]  tmo_r, tmo_s;
    logic [N-1:0]    dmask_r, dmask_s;
    logic            acc_s;
    logic            abort_exit_s;
    logic [TW-1:0]   feed_last_s;
    logic            mesh_rstn_s;
    logic [N-1:0]    rd_en_s;
    logic            valid_s;
    logic            last_s;
    logic            busy_s;
    logic            done_s;
    logic            error_s;

    assign feed_last_s = TW'(k_r) + TW'(N - 1) - TW'(1);

    // Next-state, counter and next-output computation.
    always_comb begin
        state_s      = state_r;
        k_s          = k_r;
        t_s          = t_r;
        clr_s        = clr_r;
        tmo_s        = tmo_r;
        dmask_s      = dmask_r;
        acc_s        = acc_sel_o;
        abort_exit_s = 1'b0;
        error_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (k_len_i != {KW{1'b0}}) begin
                        state_s = ST_CLEAR;
                        k_s     = k_len_i;
                        acc_s   = acc_sel_i;
                        clr_s   = {CW{1'b0}};
                    end else begin
                        error_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                dmask_s = {N{1'b0}};
                t_s     = {TW{1'b0}};
                if (abort_i) begin
                    state_s      = ST_IDLE;
                    abort_exit_s = 1'b1;
                end else if (clr_r == CW'(CLR_CYCLES - 1)) begin
                    state_s = ST_FEED;
                end else begin
                    clr_s = clr_r + CW'(1);
                end
            end
            ST_FEED: begin
                dmask_s = dmask_r | drain_i;
                if (abort_i) begin
                    state_s      = ST_IDLE;
                    abort_exit_s = 1'b1;
                end else if (t_r == feed_last_s) begin
                    state_s = ST_WAIT;
                    tmo_s   = {TOW{1'b0}};
                end else begin
                    t_s = t_r + TW'(1);
                end
            end
            ST_WAIT: begin
                dmask_s = dmask_r | drain_i;
                // Abort beats completion, completion beats the timeout.
                if (abort_i) begin
                    state_s      = ST_IDLE;
                    abort_exit_s = 1'b1;
                end else if (mesh_done_i && (&(dmask_r | drain_i))) begin
                    state_s = ST_DONE;
                end else if (tmo_r == TOW'(TIMEOUT - 1)) begin
                    state_s = ST_IDLE;
                    error_s = 1'b1;
                end else begin
                    tmo_s = tmo_r + TOW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are computed from the next state so that the registered
        // outputs line up with the state they describe.
        for (int r = 0; r < N; r++) begin
            rd_en_s[r] = (state_s == ST_FEED) && (t_s >= TW'(r)) &&
                         (t_s < (TW'(r) + TW'(k_r)));
        end
        valid_s     = rd_en_s[0];
        last_s      = (state_s == ST_FEED) && (t_s == feed_last_s);
        mesh_rstn_s = !((state_s == ST_CLEAR) || abort_exit_s);
        busy_s      = (state_s != ST_IDLE);
        done_s      = (state_s == ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= ST_IDLE;
            k_r            <= {KW{1'b0}};
            t_r            <= {TW{1'b0}};
            clr_r          <= {CW{1'b0}};
            tmo_r          <= {TOW{1'b0}};
            dmask_r        <= {N{1'b0}};
            mesh_rstn_o    <= 1'b0;
            queue_rd_en_o  <= {N{1'b0}};
            inputs_valid_o <= 1'b0;
            last_element_o <= 1'b0;
            acc_sel_o      <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            state_r        <= state_s;
            k_r            <= k_s;
            t_r            <= t_s;
            clr_r          <= clr_s;
            tmo_r          <= tmo_s;
            dmask_r        <= dmask_s;
            mesh_rstn_o    <= mesh_rstn_s;
            queue_rd_en_o  <= rd_en_s;
            inputs_valid_o <= valid_s;
            last_element_o <= last_s;
            acc_sel_o      <= acc_s;
            busy_o         <= busy_s;
            done_o         <= done_s;
            error_o        <= error_s;
        end
    end

endmodule

// File: tb/tb_mesh_sequencer.sv
// Testbench for mesh_sequencer: each job is described by a few cycle
// offsets (clear length, feed window, wait window, completion/abort edge)
// and the expected output word for every cycle is derived from them.
module tb_mesh_sequencer;

    localparam int N   = 4;
    localparam int KW  = 8;
    localparam int CLR = 2;
    localparam int TMO = 16;
    localparam int OW  = N + 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] klen;
    logic          acc_in;
    logic          abort;
    logic          mdone;
    logic [N-1:0]  drain;
    logic          mesh_rstn;
    logic [N-1:0]  rd_en;
    logic          valid;
    logic          last;
    logic          acc_out;
    logic          busy;
    logic          done;
    logic          error;

    mesh_sequencer #(.N(N), .KW(KW), .CLR_CYCLES(CLR), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(klen),
        .acc_sel_i(acc_in), .abort_i(abort), .mesh_done_i(mdone),
        .drain_i(drain), .mesh_rstn_o(mesh_rstn), .queue_rd_en_o(rd_en),
        .inputs_valid_o(valid), .last_element_o(last), .acc_sel_o(acc_out),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int jobn     = 0;

    // Job scenario (kind: 0 runs to completion/timeout, 1 abort, 2 reset).
    int sk, cw0, kind, ea, e_done, nat_end, end_e;
    bit sacc, hd, last_acc;
    int drain_e [N];

    task automatic check_eq(input string tag, input logic [OW-1:0] obs,
                            input logic [OW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got={rstn,rd,v,last,acc,busy,done,err}=%b want=%b",
                     tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] observed();
        return {mesh_rstn, rd_en, valid, last, acc_out, busy, done, error};
    endfunction

    function automatic logic [OW-1:0] idle_word(input bit a, input bit e);
        return {1'b1, {N{1'b0}}, 1'b0, 1'b0, a, 1'b0, 1'b0, e};
    endfunction

    // Expected outputs after the c-th edge of the current job (start sampled at edge 1).
    function automatic logic [OW-1:0] exp_at(input int c);
        logic         rstn = 1'b1;
        logic [N-1:0] rd   = '0;
        logic         lst  = 1'b0;
        logic         a    = sacc;
        logic         b    = 1'b0;
        logic         d    = 1'b0;
        logic         e    = 1'b0;
        int           t;
        if (kind != 0 && c >= ea) begin
            if (kind == 2) a = 1'b0;
            if (c == ea) rstn = 1'b0;
        end else if (c <= CLR) begin
            rstn = 1'b0;
            b    = 1'b1;
        end else if (c < cw0) begin
            t = c - CLR - 1;
            for (int r = 0; r < N; r++) rd[r] = (t >= r) && (t < r + sk);
            lst = (t == sk + N - 2);
            b   = 1'b1;
        end else if (c < nat_end) begin
            b = 1'b1;
        end else if (c == nat_end) begin
            if (hd) begin
                b = 1'b1;
                d = 1'b1;
            end else begin
                e = 1'b1;
            end
        end
        return {rstn, rd, rd[0], lst, a, b, d, e};
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; klen = '0; acc_in = 1'b0;
        abort = 1'b0; mdone = 1'b0; drain = '0;
    endtask

    task automatic run_job(input int k, input bit a, input int kind_i,
                           input int ea_i, input bit hd_i, input bit ordered);
        int m;
        jobn++;
        sk = k; sacc = a; kind = kind_i; hd = hd_i;
        cw0 = CLR + k + N;
        for (int r = 0; r < N; r++)
            drain_e[r] = ordered ? (cw0 + 1 + r) : $urandom_range(cw0 + 6, CLR + 2);
        e_done = ordered ? (cw0 + N + 1) : $urandom_range(cw0 + 6, CLR + 2);
        if (hd) begin
            m = (e_done > cw0 + 1) ? e_done : cw0 + 1;
            for (int r = 0; r < N; r++) if (drain_e[r] > m) m = drain_e[r];
            nat_end = m;
        end else begin
            nat_end = cw0 + TMO;
        end
        if (kind == 0) ea = 0;
        else if (ea_i != 0) ea = ea_i;
        else ea = $urandom_range(nat_end, 2);
        end_e = (kind == 0) ? nat_end : ea;
        for (int c = 1; c <= end_e + 1; c++) begin
            start  = (c == 1) || (c >= 2 && c <= end_e && $urandom_range(3, 0) == 0);
            klen   = (c == 1) ? k[KW-1:0] : KW'($urandom_range(255, 0));
            acc_in = (c == 1) ? a : 1'($urandom_range(1, 0));
            for (int r = 0; r < N; r++) drain[r] = (drain_e[r] == c);
            mdone  = hd && (c >= e_done) && (c <= end_e);
            abort  = (kind == 1) && (c == ea);
            rst    = (kind == 2) && (c == ea);
            @(posedge clk);
            #1;
            check_eq($sformatf("job%0d_c%0d", jobn, c), observed(), exp_at(c));
        end
        idle_inputs();
        last_acc = (kind == 2) ? 1'b0 : a;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle", observed(), idle_word(last_acc, 1'b0));
        end
    endtask

    task automatic reject_start(input bit a);
        start = 1'b1; klen = '0; acc_in = a;
        @(posedge clk);
        #1;
        start = 1'b0; acc_in = 1'b0;
        check_eq("k0_error", observed(), idle_word(last_acc, 1'b1));
        idle_cycles(1);
    endtask

    initial begin
        int x, kr;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", observed(), {OW{1'b0}});
        rst = 1'b0;
        last_acc = 1'b0;
        idle_cycles(2);

        run_job(3, 1'b1, 0, 0, 1'b1, 1'b1);      // K=3 feed shape, ordered drains then done
        idle_cycles(1);
        reject_start(1'b0);                      // K=0 rejected
        run_job(2, 1'b0, 0, 0, 1'b0, 1'b0);      // no done flag -> timeout
        run_job(5, 1'b1, 1, CLR + 4, 1'b1, 1'b0); // abort at t=2 of FEED
        idle_cycles(1);
        run_job(4, 1'b1, 2, CLR + 3, 1'b1, 1'b0); // reset at t=1 of FEED
        run_job(3, 1'b1, 0, 0, 1'b1, 1'b0);      // normal job after reset
        run_job(1, 1'b0, 0, 0, 1'b1, 1'b0);      // K=1 single-cycle enables

        for (int j = 0; j < 40; j++) begin
            x  = $urandom_range(7, 0);
            kr = ($urandom_range(4, 0) == 0) ? $urandom_range(20, 7) : $urandom_range(6, 1);
            run_job(kr, 1'($urandom_range(1, 0)), (x == 6) ? 1 : ((x == 7) ? 2 : 0),
                    0, ($urandom_range(5, 0) != 0), 1'b0);
            if ($urandom_range(4, 0) == 0) reject_start(1'($urandom_range(1, 0)));
            idle_cycles($urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
